// File: rtl/cell_scan_ctrl.sv
// ---------------------------------------------------------------------------
// cell_scan_ctrl
//
// Purpose:
//   Holds DEPTH cell slots. A scan request walks the slots in order, one per
//   clock. Each slot's fields and the request handle go to an external
//   combinational enRange evaluator. The block counts the slots the evaluator
//   reports as hits and keeps the index and value of the first hit. The
//   result is returned through a valid/ready response handshake.
//
// Configuration:
//   SCAN_EARLY_EXIT_EN - when defined, a scan stops on the first hit. In that
//                        build rsp_count is 0 or 1 and the response arrives
//                        (hit index + 1) edges after acceptance. Without the
//                        macro, every slot is always scanned and every hit is
//                        counted.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   wr_en, wr_addr,    cell write. It is taken only while the controller is
//   wr_cell            idle. wr_cell = {eltDef, isMetadata, metadata, low,
//                      high, rsvd}.
//   req_valid/ready,   scan request handshake and handle to match
//   req_handle
//   op_*               slot fields and latched handle to the evaluator.
//                      These are zero outside a scan.
//   op_resultBool,     evaluator hit flag and value, same cycle
//   op_resultValue
//   rsp_valid/ready    response handshake
//   rsp_hit, rsp_count,
//   rsp_index, rsp_value
//                      scan result, held stable while rsp_valid is high
// ---------------------------------------------------------------------------
module cell_scan_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [33:0]   wr_cell,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_handle,
  output logic          op_eltDef,
  output logic          op_isMetadata,
  output logic [7:0]    op_handle,
  output logic [7:0]    op_metadata,
  output logic [7:0]    op_low,
  output logic [7:0]    op_high,
  input  logic          op_resultBool,
  input  logic [7:0]    op_resultValue,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [AW:0]   rsp_count,
  output logic [AW-1:0] rsp_index,
  output logic [7:0]    rsp_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW:0]   count_reg, count_next;
  logic          hit_reg, hit_next;
  logic [AW-1:0] index_reg, index_next;
  logic [7:0]    value_reg, value_next;
  logic [7:0]    handle_reg, handle_next;

  // Cell storage. eltDef has a reset so that stale slots never look defined.
  // The remaining fields carry no reset because they do not matter while
  // eltDef is 0.
  logic [DEPTH-1:0] elt_def_reg;
  logic             is_meta_reg [DEPTH];
  logic [7:0]       meta_reg    [DEPTH];
  logic [7:0]       low_reg     [DEPTH];
  logic [7:0]       high_reg    [DEPTH];

  logic       wr_fire;
  logic       scan_active;
  logic       last_slot;
  logic [7:0] rsvd_unused;

  // The rsvd byte of a cell is not stored.
  assign rsvd_unused = wr_cell[7:0];

  assign wr_fire     = wr_en && (state_reg == IDLE);
  assign scan_active = (state_reg == SCAN);
  assign last_slot   = (idx_reg == AW'(DEPTH - 1));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          elt_def_reg[gi] <= 1'b0;
        end else if (wr_fire && (wr_addr == AW'(gi))) begin
          elt_def_reg[gi] <= wr_cell[33];
        end
      end

      always_ff @(posedge clk) begin
        if (wr_fire && (wr_addr == AW'(gi))) begin
          is_meta_reg[gi] <= wr_cell[32];
          meta_reg[gi]    <= wr_cell[31:24];
          low_reg[gi]     <= wr_cell[23:16];
          high_reg[gi]    <= wr_cell[15:8];
        end
      end
    end
  endgenerate

  // The evaluator path is combinational. A write and an acceptance on the
  // same edge land the cell before the first SCAN cycle reads it.
  assign op_eltDef     = scan_active ? elt_def_reg[idx_reg] : 1'b0;
  assign op_isMetadata = scan_active ? is_meta_reg[idx_reg] : 1'b0;
  assign op_handle     = scan_active ? handle_reg           : 8'h00;
  assign op_metadata   = scan_active ? meta_reg[idx_reg]    : 8'h00;
  assign op_low        = scan_active ? low_reg[idx_reg]     : 8'h00;
  assign op_high       = scan_active ? high_reg[idx_reg]    : 8'h00;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign rsp_hit   = hit_reg;
  assign rsp_count = count_reg;
  assign rsp_index = index_reg;
  assign rsp_value = value_reg;

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    count_next  = count_reg;
    hit_next    = hit_reg;
    index_next  = index_reg;
    value_next  = value_reg;
    handle_next = handle_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          handle_next = req_handle;
          idx_next    = '0;
          count_next  = '0;
          hit_next    = 1'b0;
          index_next  = '0;
          value_next  = 8'h00;
          state_next  = SCAN;
        end
      end

      SCAN: begin
        if (op_resultBool) begin
          count_next = count_reg + 1'b1;
          // Only the first hit of a scan is reported as index/value.
          if (!hit_reg) begin
            hit_next   = 1'b1;
            index_next = idx_reg;
            value_next = op_resultValue;
          end
        end
        // idx stops at the last slot instead of wrapping.
        if (last_slot) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
`ifdef SCAN_EARLY_EXIT_EN
        if (op_resultBool) begin
          state_next = DONE;
        end
`endif
      end

      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      count_reg  <= '0;
      hit_reg    <= 1'b0;
      index_reg  <= '0;
      value_reg  <= 8'h00;
      handle_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      count_reg  <= count_next;
      hit_reg    <= hit_next;
      index_reg  <= index_next;
      value_reg  <= value_next;
      handle_reg <= handle_next;
    end
  end

endmodule
